// File: rtl/c_hazard_unit.sv
// -----------------------------------------------------------------------------
// c_hazard_unit
//
// Hazard detection and forwarding control for a five-stage pipeline with a
// multi-cycle execute unit.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   Rs1D, Rs2D                 : decode-stage source registers
//   Rs1E, Rs2E, RdE            : execute-stage sources / destination
//   RdM, RdW                   : memory / writeback destinations
//   RegWE_E_E, RegWE_W_E       : execute dest written by EX result / by a
//                                writeback-only result (e.g. a load)
//   RegWE_M, RegWE_W_M         : memory stage writes (any path / WB-only path)
//   RegWE_W                    : writeback stage writes a register
//   BranchTakenE               : execute redirects the PC
//   ms_start_E, ms_done        : multi-cycle op present in E / result valid
//   StallF, StallD, StallE     : pipeline-register hold controls
//   FlushD, FlushE             : pipeline-register bubble controls
//   ForwardAE, ForwardBE       : 00 regfile, 01 W result, 10 M result
//   ms_go                      : one-cycle start pulse to the multi-cycle unit
//   ms_timeout                 : one-cycle watchdog pulse
//   fsm_busy_dbg               : 1 while the multi-cycle FSM is in BUSY
//
// Configuration macro: HAZARD_FORWARD_EN
//   defined   : M/W forwarding into execute; only writeback-only producers
//               (loads) in E or M stall decode.
//   undefined : no forwarding (Forward*E tied to 00); any pending write in E
//               or M with a matching decode source stalls decode.
//
// Handshake with the multi-cycle unit: ms_go pulses in the first cycle the op
// is seen in execute; the unit answers with ms_done for one cycle. The stall is
// released in the ms_done cycle itself, so the op leaves E at the next edge.
// -----------------------------------------------------------------------------
module c_hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWE_E_E,
    input  logic       RegWE_W_E,
    input  logic       RegWE_M,
    input  logic       RegWE_W_M,
    input  logic       RegWE_W,
    input  logic       BranchTakenE,
    input  logic       ms_start_E,
    input  logic       ms_done,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ms_go,
    output logic       ms_timeout,
    output logic       fsm_busy_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic ms_stall;
    logic ms_go_raw;
    logic ms_timeout_raw;

    // A producer is "pending" when its value cannot yet reach decode's consumer
    // in time, so decode must wait one more cycle.
    logic e_pending;
    logic m_pending;
    logic data_hazard;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

`ifdef HAZARD_FORWARD_EN
    logic m_fwd_ok;
    logic w_fwd_ok;
    logic unused_fwd_inputs;

    assign e_pending = RegWE_W_E;
    assign m_pending = RegWE_W_M;

    // M can only forward an EX-computed value; a WB-only result in M is not
    // available yet and is handled by the decode stall instead.
    assign m_fwd_ok = RegWE_M && !RegWE_W_M && (RdM != 5'd0);
    assign w_fwd_ok = RegWE_W && (RdW != 5'd0);

    assign fwd_a = (m_fwd_ok && (RdM == Rs1E)) ? 2'b10 :
                   (w_fwd_ok && (RdW == Rs1E)) ? 2'b01 : 2'b00;
    assign fwd_b = (m_fwd_ok && (RdM == Rs2E)) ? 2'b10 :
                   (w_fwd_ok && (RdW == Rs2E)) ? 2'b01 : 2'b00;

    assign unused_fwd_inputs = RegWE_E_E;
`else
    logic unused_fwd_inputs;

    assign e_pending = RegWE_E_E | RegWE_W_E;
    assign m_pending = RegWE_M;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;

    assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW, RegWE_W, RegWE_W_M};
`endif

    // W is never checked: the register file writes through to decode.
    assign data_hazard =
        ((Rs1D != 5'd0) && ((e_pending && (RdE == Rs1D)) || (m_pending && (RdM == Rs1D)))) ||
        ((Rs2D != 5'd0) && ((e_pending && (RdE == Rs2D)) || (m_pending && (RdM == Rs2D))));

    // Multi-cycle FSM next state. Counter value k means BUSY cycle k+1.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ms_stall       = 1'b0;
        ms_go_raw      = 1'b0;
        ms_timeout_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (ms_start_E) begin
                    ms_go_raw = 1'b1;
                    // A same-cycle answer needs no stall and no BUSY visit.
                    if (!ms_done) begin
                        ms_stall = 1'b1;
                        state_d  = BUSY;
                        cnt_d    = 6'd0;
                    end
                end
            end
            BUSY: begin
                if (ms_done) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd63) begin
                    ms_timeout_raw = 1'b1;
                    state_d        = IDLE;
                end else begin
                    ms_stall = 1'b1;
                    cnt_d    = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline controls. The multi-cycle stall freezes everything, so it masks
    // both flushes; a taken branch discards decode, so its hazard stall is moot.
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        ForwardAE    = 2'b00;
        ForwardBE    = 2'b00;
        ms_go        = 1'b0;
        ms_timeout   = 1'b0;
        fsm_busy_dbg = 1'b0;
        if (!reset) begin
            StallE       = ms_stall;
            StallF       = ms_stall | (data_hazard & ~BranchTakenE);
            StallD       = ms_stall | (data_hazard & ~BranchTakenE);
            FlushD       = BranchTakenE & ~ms_stall;
            FlushE       = (BranchTakenE | data_hazard) & ~ms_stall;
            ForwardAE    = fwd_a;
            ForwardBE    = fwd_b;
            ms_go        = ms_go_raw;
            ms_timeout   = ms_timeout_raw;
            fsm_busy_dbg = (state_q == BUSY);
        end
    end

endmodule
